// File: rtl/bus_dump_uart.sv
// bus_dump_uart
// Walks an inclusive address range on an external parallel read bus. For each
// address it holds the read strobe low for a programmable settle time, captures
// the data word, then sends that word out an 8N1 UART transmitter with the
// least significant byte first. A dump can be aborted. The abort takes effect
// only at the end of a stop bit, so a UART frame is never cut short.
//
// Ports:
//   CLOCK_50    sole clock, rising edge
//   RESET_N     asynchronous active-low reset
//   start       one-cycle dump request; honoured only when idle
//   abort       level; ends the dump at the next byte boundary
//   start_addr  first address; latched when start is accepted
//   end_addr    last address (inclusive); latched when start is accepted
//   bus_a       external address
//   bus_rd_n    external read strobe, active low
//   bus_d       external read data
//   tx          UART serial output; idles high
//   busy        high while a dump is in progress
//   done        one-cycle pulse after a dump completes without abort
//   word_count  number of words fully transmitted in the current or last dump
module bus_dump_uart #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 434,
  parameter int SETTLE  = 4
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] bus_a,
  output logic              bus_rd_n,
  input  logic [DATA_W-1:0] bus_d,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   end_addr_reg;
  logic [ADDR_W-1:0]   bus_a_reg;
  logic                bus_rd_n_reg;
  logic                tx_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [ADDR_W:0]     word_count_reg;
  logic [DATA_W-1:0]   word_reg;       // low byte is always the byte being sent
  logic [IDX_W-1:0]    idx_reg;        // byte index within the current word
  logic [DIV_W-1:0]    div_cnt_reg;    // cycle within the current bit
  logic [3:0]          bit_pos_reg;    // 0 = start bit, 1..8 = data bits, 9 = stop bit
  logic [SET_W-1:0]    settle_cnt_reg;

  assign bus_a      = bus_a_reg;
  assign bus_rd_n   = bus_rd_n_reg;
  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign word_count = word_count_reg;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= ST_IDLE;
      end_addr_reg   <= '0;
      bus_a_reg      <= '0;
      bus_rd_n_reg   <= 1'b1;
      tx_reg         <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      word_count_reg <= '0;
      word_reg       <= '0;
      idx_reg        <= '0;
      div_cnt_reg    <= '0;
      bit_pos_reg    <= '0;
      settle_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            end_addr_reg   <= end_addr;
            bus_a_reg      <= start_addr;
            word_count_reg <= '0;
            bus_rd_n_reg   <= 1'b0;
            busy_reg       <= 1'b1;
            settle_cnt_reg <= '0;
            state_reg      <= ST_READ;
          end
        end

        ST_READ: begin
          if (settle_cnt_reg == SET_W'(SETTLE - 1)) begin
            // Capture on the last settle cycle. The start bit goes out in
            // the very next cycle, the same cycle the strobe is released.
            word_reg     <= bus_d;
            bus_rd_n_reg <= 1'b1;
            idx_reg      <= '0;
            div_cnt_reg  <= '0;
            bit_pos_reg  <= '0;
            tx_reg       <= 1'b0;
            state_reg    <= ST_SEND;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end

        ST_SEND: begin
          if (div_cnt_reg != DIV_W'(CLK_DIV - 1)) begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end else begin
            div_cnt_reg <= '0;
            if (bit_pos_reg != 4'd9) begin
              bit_pos_reg <= bit_pos_reg + 1'b1;
              // Load the value of the bit that starts next. Position p+1
              // (1..8) carries data bit p. Position 9 is the stop bit.
              if (bit_pos_reg == 4'd8) begin
                tx_reg <= 1'b1;
              end else begin
                tx_reg <= word_reg[bit_pos_reg[2:0]];
              end
            end else if (abort) begin
              busy_reg  <= 1'b0;
              state_reg <= ST_IDLE;
            end else if (idx_reg != IDX_W'(BYTES - 1)) begin
              // Next byte follows immediately with no idle bit between frames.
              idx_reg     <= idx_reg + 1'b1;
              word_reg    <= word_reg >> 8;
              bit_pos_reg <= '0;
              tx_reg      <= 1'b0;
            end else begin
              word_count_reg <= word_count_reg + 1'b1;
              state_reg      <= ST_NEXT;
            end
          end
        end

        ST_NEXT: begin
          if (bus_a_reg == end_addr_reg) begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            // The address wraps naturally at 2^ADDR_W.
            bus_a_reg      <= bus_a_reg + ADDR_W'(1);
            bus_rd_n_reg   <= 1'b0;
            settle_cnt_reg <= '0;
            state_reg      <= ST_READ;
          end
        end

        ST_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg    <= ST_IDLE;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b0;
          bus_rd_n_reg <= 1'b1;
          tx_reg       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dump_uart.sv
// Testbench for bus_dump_uart. It uses random memory contents and random
// ranges. A UART decoder acts as the monitor and checks each byte against a
// queue of expected bytes. The queue is filled from a simple address-walk model
// of the memory.
module tb_bus_dump_uart;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int CLK_DIV = 4;
  localparam int SETTLE  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [ADDR_W-1:0] bus_a;
  logic              bus_rd_n;
  logic [DATA_W-1:0] bus_d;
  logic              tx;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_count;

  logic [DATA_W-1:0] mem [0:255];

  int   n_cmp = 0;
  int   n_err = 0;
  int   frames_started = 0;
  int   done_count = 0;
  int   cyc = 0;
  bit   mon_en = 1'b1;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus model: memory read while the strobe is low, garbage otherwise.
  assign bus_d = bus_rd_n ? 16'hDEAD : mem[bus_a];

  bus_dump_uart #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .SETTLE(SETTLE)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr), .bus_a(bus_a),
    .bus_rd_n(bus_rd_n), .bus_d(bus_d), .tx(tx), .busy(busy), .done(done),
    .word_count(word_count)
  );

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // UART monitor: samples each bit on CLK_DIV consecutive falling edges. The
  // bit must hold steady for the whole period.
  initial begin : uart_mon
    logic [9:0] bits;
    bit stable;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        frames_started++;
        stable = 1'b1;
        bits = '0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < CLK_DIV; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (k == 0) bits[b] = tx;
            else if (tx !== bits[b]) stable = 1'b0;
          end
        end
        if (mon_en) begin
          check("bit_period_stable", stable, 1);
          check("stop_bit", bits[9], 1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got %0h, expected none", bits[8:1]);
          end else begin
            check("uart_byte", bits[8:1], exp_q.pop_front());
          end
        end
      end
    end
  end

  // Read strobe monitor: each low run must last exactly SETTLE cycles.
  initial begin : rd_mon
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) run = 0;
      else if (bus_rd_n === 1'b0) run++;
      else begin
        if (run != 0 && mon_en) check("rd_low_cycles", run, SETTLE);
        run = 0;
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_count++;
        check("busy_during_done", busy, 1);
      end
    end
  end

  task automatic pulse_start(input logic [7:0] s, input logic [7:0] e);
    @(posedge clk); #1;
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  // Reference model: walk from s to e inclusive, modulo 256, with the low byte
  // of each word first.
  task automatic push_expected(input logic [7:0] s, input logic [7:0] e, output int nwords);
    logic [7:0] a;
    nwords = ((int'(e) - int'(s) + 256) % 256) + 1;
    for (int i = 0; i < nwords; i++) begin
      a = s + 8'(i);
      exp_q.push_back(mem[a][7:0]);
      exp_q.push_back(mem[a][15:8]);
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout, busy=%b expected 0", name, busy);
    end
  endtask

  task automatic run_dump(input logic [7:0] s, input logic [7:0] e, input bit poke);
    int nw;
    int dc0;
    dc0 = done_count;
    pulse_start(s, e);
    check("cycle1_busy", busy, 1);
    check("cycle1_rd_n", bus_rd_n, 0);
    check("cycle1_bus_a", bus_a, s);
    push_expected(s, e, nw);
    if (poke) begin
      repeat (30) @(posedge clk);
      #1;
      start_addr = 8'($urandom);
      end_addr   = 8'($urandom);
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
    end
    wait_idle("dump_finish");
    check("word_count", word_count, nw);
    check("done_pulses", done_count - dc0, 1);
    check("queue_drained", exp_q.size(), 0);
    check("bus_a_holds_end", bus_a, e);
    check("tx_idle", tx, 1);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] s;
    logic [7:0] e;
    int t;
    int t0;
    int dc0;
    int f0;
    int lows;

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[5] = 16'hBEEF;

    // Reset values, checked while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_a", bus_a, 0);
    check("rst_rd_n", bus_rd_n, 1);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_word_count", word_count, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Basic range, then a range that wraps through 0xFF.
    run_dump(8'h10, 8'h13, 1'b0);
    run_dump(8'hFE, 8'h01, 1'b0);

    // A single 16-bit word. The two bytes go out back to back, so done lands
    // 80 frame cycles plus the NEXT cycle after the first start bit.
    dc0 = done_count;
    pulse_start(8'h05, 8'h05);
    push_expected(8'h05, 8'h05, t);
    t = 0;
    while (tx !== 1'b0 && t < 500) begin @(negedge clk); t++; end
    t0 = cyc;
    t = 0;
    while (done !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    check("beef_done_latency", cyc - t0, 81);
    wait_idle("beef_finish");
    check("beef_word_count", word_count, 1);
    check("beef_done_pulses", done_count - dc0, 1);
    check("beef_queue_drained", exp_q.size(), 0);
    exp_q.delete();

    // Random ranges. One of them gets an extra start pulse while busy.
    for (int i = 0; i < 3; i++) begin
      s = 8'($urandom);
      e = s + 8'($urandom_range(0, 4));
      run_dump(s, e, i == 1);
    end

    // Abort raised during the start bit of word 2. Only that byte finishes.
    dc0 = done_count;
    s = 8'($urandom);
    e = s + 8'd7;
    f0 = frames_started;
    pulse_start(s, e);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mem[8'(s + 8'(i))][7:0]);
      if (i < 2) exp_q.push_back(mem[8'(s + 8'(i))][15:8]);
    end
    t = 0;
    while (frames_started < f0 + 5 && t < 2000) begin @(negedge clk); t++; end
    abort = 1'b1;
    wait_idle("abort_finish");
    abort = 1'b0;
    lows = 0;
    repeat (20) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    check("abort_tx_idle_cycles_low", lows, 0);
    check("abort_word_count", word_count, 2);
    check("abort_no_done", done_count - dc0, 0);
    check("abort_frames", frames_started - f0, 5);
    check("abort_queue_drained", exp_q.size(), 0);
    exp_q.delete();

    // Asynchronous reset in the middle of a data bit.
    mon_en = 1'b0;
    f0 = frames_started;
    pulse_start(8'h40, 8'h43);
    t = 0;
    while (frames_started == f0 && t < 500) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_rd_n", bus_rd_n, 1);
    check("async_rst_word_count", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    mon_en = 1'b1;

    // A normal dump still works after the reset.
    run_dump(8'h20, 8'h21, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
